// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the pipelined integer ALU.
//   - op codes ALU_ADD..ALU_AND, plus RV64 word ops ALU_ADDW..ALU_SRAW
//   - sideband field widths and the packed sideband layouts
//   - in_w()/out_w(): bundle widths as a function of XLEN
package alu_pkg;

    localparam int unsigned RD_W  = 5;
    localparam int unsigned IMM_W = 12;
    localparam int unsigned OPT_W = 5;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CTL_W = RD_W + IMM_W + OPT_W + OP_W + TAG_W;

    localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_AND  = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_ADDW = OP_W'(11);
    localparam logic [OP_W-1:0] ALU_SUBW = OP_W'(12);
    localparam logic [OP_W-1:0] ALU_SLLW = OP_W'(13);
    localparam logic [OP_W-1:0] ALU_SRLW = OP_W'(14);
    localparam logic [OP_W-1:0] ALU_SRAW = OP_W'(15);

    // Low CTL_W bits of in_data, below the two operands.
    typedef struct packed {
        logic [RD_W-1:0]  rd_idex;
        logic [IMM_W-1:0] imm;
        logic [OPT_W-1:0] op_type;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] itag;
    } ctl_t;

    // Low bits of out_data, below the result.
    typedef struct packed {
        logic [RD_W-1:0]  rd_idex;
        logic [TAG_W-1:0] itag;
    } wb_tag_t;

    function automatic int unsigned in_w(input int unsigned xlen);
        return 2 * xlen + CTL_W;
    endfunction

    function automatic int unsigned out_w(input int unsigned xlen);
        return xlen + RD_W + TAG_W;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU function (op, rs1, rs2) -> result.
//   op     in  OP_W   operation code (see alu_pkg)
//   rs1    in  XLEN   first operand
//   rs2    in  XLEN   second operand / shift amount
//   result out XLEN   result; 0 for unknown ops
// Build option: define ALU_WORD_OP_EN (XLEN=64 only) to decode the
// RV64 word ops 11..15; without it those codes return 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] result
);

    logic [SHW-1:0] shamt;
    assign shamt = rs2[SHW-1:0];

`ifdef ALU_WORD_OP_EN
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic [4:0]  w_sh;
    assign w_rs1 = rs1[31:0];
    assign w_rs2 = rs2[31:0];
    assign w_sh  = rs2[4:0];
`endif

    // Word results are formed at 32 bits, then sign-extended by the signed cast.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = rs1 + rs2;
            ALU_SUB:  result = rs1 - rs2;
            ALU_SLL:  result = rs1 << shamt;
            ALU_SLT:  result = XLEN'($signed(rs1) < $signed(rs2));
            ALU_SLTU: result = XLEN'(rs1 < rs2);
            ALU_XOR:  result = rs1 ^ rs2;
            ALU_SRL:  result = rs1 >> shamt;
            ALU_SRA:  result = XLEN'($signed(rs1) >>> shamt);
            ALU_OR:   result = rs1 | rs2;
            ALU_AND:  result = rs1 & rs2;
`ifdef ALU_WORD_OP_EN
            ALU_ADDW: result = XLEN'($signed(32'(w_rs1 + w_rs2)));
            ALU_SUBW: result = XLEN'($signed(32'(w_rs1 - w_rs2)));
            ALU_SLLW: result = XLEN'($signed(32'(w_rs1 << w_sh)));
            ALU_SRLW: result = XLEN'($signed(32'(w_rs1 >> w_sh)));
            ALU_SRAW: result = XLEN'($signed(w_rs1) >>> w_sh);
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage integer ALU for the execute stage.
//   clk, rst_n  clock, async active-low reset
//   in_valid    in   operation present on in_data
//   in_ready    out  accept this cycle (combinational from out_ready)
//   in_data     in   {rs1, rs2, rd_idex, imm, op_type, op, itag}
//   flush       in   drop everything in flight at the next edge
//   out_valid   out  result present on out_data
//   out_ready   in   consumer takes the result
//   out_data    out  {rd_wb, rd_idex, itag}
//   rd_en       out  register-file write enable (= out_valid)
// Build option: ALU_WORD_OP_EN enables RV64 word ops inside alu_core.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [in_w(XLEN)-1:0]    in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [out_w(XLEN)-1:0]   out_data,
    output logic                     rd_en
);

    localparam int unsigned IN_W = in_w(XLEN);

    logic            s1_valid;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_rs2;
    ctl_t            s1_ctl;

    logic            s2_valid;
    logic [XLEN-1:0] s2_result;
    wb_tag_t         s2_tag;

    logic            s1_adv;
    logic            s2_adv;
    logic [XLEN-1:0] core_result;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: capture the operand bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_ctl   <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s1_adv && in_valid && !flush) begin
                s1_rs1 <= in_data[IN_W-1 -: XLEN];
                s1_rs2 <= in_data[CTL_W +: XLEN];
                s1_ctl <= ctl_t'(in_data[CTL_W-1:0]);
            end
        end
    end

    alu_core #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_core (
        .op     (s1_ctl.op),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .result (core_result)
    );

    // Stage 2: register the result; data holds during a stall or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv && s1_valid && !flush) begin
                s2_result      <= core_result;
                s2_tag.rd_idex <= s1_ctl.rd_idex;
                s2_tag.itag    <= s1_ctl.itag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign rd_en     = s2_valid;
    assign out_data  = {s2_result, s2_tag};

    // imm and op_type ride along in S1 but feed no logic.
    logic unused_ctl;
    assign unused_ctl = ^{s1_ctl.imm, s1_ctl.op_type};

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: XLEN=64 instance with directed and random traffic
// against a scoreboard model, plus an XLEN=32 instance for narrow cases.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned IW   = in_w(64);
    localparam int unsigned OW   = out_w(64);
    localparam int unsigned IW32 = in_w(32);
    localparam int unsigned OW32 = out_w(32);
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready, rd_en;
    logic [IW-1:0] in_data;
    logic [OW-1:0] out_data;

    logic            v32, rdy32, fl32, ov32, or32, rden32;
    logic [IW32-1:0] d32;
    logic [OW32-1:0] od32;

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .rd_en(rd_en)
    );

    alu_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
        .in_data(d32), .flush(fl32), .out_valid(ov32),
        .out_ready(or32), .out_data(od32), .rd_en(rden32)
    );

    typedef struct {
        logic [OW-1:0] data;
        int            acc;
    } sb_t;

    sb_t        q[$];
    int         tests = 0;
    int         failed = 0;
    int         cnt = 0;
    logic [4:0] tag = 5'd0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    // Reference model built from the arithmetic definitions of each op.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        int sh;
        int wsh;
        sh  = int'(b[5:0]);
        wsh = int'(b[4:0]);
        case (op)
            5'd1:  return a + b;
            5'd2:  return a - b;
            5'd3:  return a << sh;
            5'd4:  return ((a ^ MSB) < (b ^ MSB)) ? 64'd1 : 64'd0;
            5'd5:  return (a < b) ? 64'd1 : 64'd0;
            5'd6:  return a ^ b;
            5'd7:  return a >> sh;
            5'd8:  return (a >> sh) | (a[63] ? ~(ONES >> sh) : 64'd0);
            5'd9:  return a | b;
            5'd10: return a & b;
`ifdef ALU_WORD_OP_EN
            5'd11: return sx32(a[31:0] + b[31:0]);
            5'd12: return sx32(a[31:0] - b[31:0]);
            5'd13: return sx32(a[31:0] << wsh);
            5'd14: return sx32(a[31:0] >> wsh);
            5'd15: return sx32((a[31:0] >> wsh) | (a[31] ? ~(32'hFFFF_FFFF >> wsh) : 32'd0));
`endif
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return MSB;
            3:       return ONES;
            4:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock of traffic on the 64-bit instance; outputs are checked
    // just after the falling edge, before this cycle's rising edge.
    task automatic step(input bit iv, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp,
                        input bit ordy, input bit fl);
        logic       exp_ov;
        logic       exp_rdy;
        logic [4:0] rd;
        @(negedge clk);
        rd        = tag ^ 5'h15;
        in_valid  = iv;
        in_data   = {a, b, rd, 12'($urandom), 5'($urandom), op, tag};
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (cnt - q[0].acc >= 2);
        check("out_valid", 256'(out_valid), 256'(exp_ov));
        check("rd_en", 256'(rd_en), 256'(exp_ov));
        if (exp_ov) check("out_data", 256'(out_data), 256'(q[0].data));
        exp_rdy = !(q.size() >= 2 && !ordy);
        check("in_ready", 256'(in_ready), 256'(exp_rdy));
        if (exp_ov && ordy) void'(q.pop_front());
        if (fl) q.delete();
        else if (iv && exp_rdy) q.push_back('{data: {exp, rd, tag}, acc: cnt});
        tag = tag + 5'd1;
        @(posedge clk);
        cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    endtask

    task automatic rnd(input bit ordy, input bit fl);
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        op = 5'($urandom_range(0, 15));
        a  = pick();
        b  = pick();
        step(1'b1, op, a, b, model(op, a, b), ordy, fl);
    endtask

    logic [63:0]     wexp;
    logic [OW32-1:0] e32;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        v32 = 1'b0; d32 = '0; fl32 = 1'b0; or32 = 1'b1;
        #12;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_rd_en", 256'(rd_en), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back arithmetic and signed/shift edge cases.
        step(1'b1, ALU_ADD,  64'd5, 64'd7,  64'd12, 1'b1, 1'b0);
        step(1'b1, ALU_SUB,  64'd0, 64'd1,  ONES,   1'b1, 1'b0);
        step(1'b1, ALU_SLL,  64'd1, 64'd65, 64'd2,  1'b1, 1'b0);
        step(1'b1, ALU_SLT,  MSB,   64'd0,  64'd1,  1'b1, 1'b0);
        step(1'b1, ALU_SLTU, MSB,   64'd0,  64'd0,  1'b1, 1'b0);
        step(1'b1, ALU_SRA,  MSB,   64'd63, ONES,   1'b1, 1'b0);
        step(1'b1, ALU_SRL,  MSB,   64'd63, 64'd1,  1'b1, 1'b0);
        step(1'b1, 5'd0,     64'd9, 64'd9,  64'd0,  1'b1, 1'b0);
`ifdef ALU_WORD_OP_EN
        wexp = 64'hFFFF_FFFF_8000_0000;
`else
        wexp = 64'd0;
`endif
        step(1'b1, ALU_ADDW, 64'h7FFF_FFFF, 64'd1, wexp, 1'b1, 1'b0);
        idle(3);

        // Back-pressure: four stalled cycles with input always offered.
        for (int i = 0; i < 2; i++) rnd(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) rnd(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b0);
        idle(3);

        // Flush with both stages full, op offered in the flush cycle.
        rnd(1'b0, 1'b0);
        rnd(1'b0, 1'b0);
        rnd(1'b0, 1'b1);
        idle(1);
        step(1'b1, ALU_ADD, 64'd3, 64'd4, 64'd7, 1'b1, 1'b0);
        idle(3);

        // Random traffic with random stalls and occasional flushes.
        for (int i = 0; i < 1500; i++)
            rnd(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        check("drain_empty", 256'(q.size()), 256'(0));

        // XLEN=32: shift amount masking and an unknown op.
        @(negedge clk);
        v32 = 1'b1;
        d32 = {32'h1, 32'd33, 5'd9, 12'h0, 5'h0, ALU_SLL, 5'd1};
        @(negedge clk);
        d32 = {32'd5, 32'd7, 5'd10, 12'h0, 5'h0, 5'd0, 5'd2};
        @(negedge clk);
        v32 = 1'b0;
        #1;
        e32 = {32'h2, 5'd9, 5'd1};
        check("x32_valid_sll", 256'(ov32), 256'(1));
        check("x32_sll33", 256'(od32), 256'(e32));
        @(negedge clk);
        #1;
        e32 = {32'h0, 5'd10, 5'd2};
        check("x32_op0", 256'(od32), 256'(e32));
        check("x32_op0_rd_en", 256'(rden32), 256'(1));

        // Reset in the middle of a stream clears valids without a clock edge.
        v32 = 1'b1;
        d32 = {32'd5, 32'd7, 5'd3, 12'h0, 5'h0, ALU_ADD, 5'd3};
        @(negedge clk);
        d32 = {32'd1, 32'd1, 5'd4, 12'h0, 5'h0, ALU_ADD, 5'd4};
        @(negedge clk);
        #1;
        e32 = {32'd12, 5'd3, 5'd3};
        check("x32_add", 256'(od32), 256'(e32));
        #2;
        rst_n = 1'b0;
        #1;
        check("x32_async_rst_valid", 256'(ov32), 256'(0));
        check("x32_async_rst_rd_en", 256'(rden32), 256'(0));
        check("async_rst_valid64", 256'(out_valid), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
